// File: rtl/bsp_pkg.sv
// Shared types for the barrel_shift_pipe slice: op encoding, stage record, width.
package bsp_pkg;
    localparam int BSP_WIDTH  = 8;
    localparam int BSP_STAGES = 3;

    typedef enum logic [1:0] {
        OP_LSL = 2'b00,
        OP_LSR = 2'b01,
        OP_ASR = 2'b10,
        OP_ROR = 2'b11
    } op_t;

    typedef struct packed {
        logic                  valid;
        logic [BSP_WIDTH-1:0]  data;
        logic [BSP_STAGES-1:0] amt;
        op_t                   op;
    } stage_t;
endpackage

// File: rtl/barrel_shift_pipe_stage.sv
// One combinational shift row: shifts by SHIFT when en is set, fill chosen by op.
module shift_stage
    import bsp_pkg::*;
#(
    parameter int SHIFT = 1
) (
    input  logic [BSP_WIDTH-1:0] din,
    input  logic                 en,
    input  op_t                  op,
    output logic [BSP_WIDTH-1:0] dout
);
    localparam int W = BSP_WIDTH;

    logic [W-1:0] shifted;

    always_comb begin
        case (op)
            OP_LSL:  shifted = {din[W-1-SHIFT:0], {SHIFT{1'b0}}};
            OP_LSR:  shifted = {{SHIFT{1'b0}}, din[W-1:SHIFT]};
            OP_ASR:  shifted = {{SHIFT{din[W-1]}}, din[W-1:SHIFT]};
            default: shifted = {din[SHIFT-1:0], din[W-1:SHIFT]};
        endcase
        dout = en ? shifted : din;
    end
endmodule

// File: rtl/barrel_shift_pipe.sv
// Three-stage pipelined 8-bit shift/rotate with valid/ready and a global stall.
// Optional out_zero flag enabled by defining BSP_ZERO_FLAG_EN.
module barrel_shift_pipe
    import bsp_pkg::*;
#(
    parameter int WIDTH  = BSP_WIDTH,
    parameter int STAGES = BSP_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_amt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef BSP_ZERO_FLAG_EN
    ,
    output logic             out_zero
`endif
);
    stage_t [STAGES-1:0] st_q;
    stage_t [STAGES-1:0] st_d;
    logic                stall;

    // Stall only when a real result is blocked; bubbles never hold up input.
    assign stall    = st_q[STAGES-1].valid && !out_ready;
    assign in_ready = !stall;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            stage_t           src;
            logic [WIDTH-1:0] shifted;

            if (k == 0) begin : g_head
                assign src = '{valid: in_valid, data: in_data, amt: in_amt, op: op_t'(in_op)};
            end else begin : g_body
                assign src = st_q[k-1];
            end

            shift_stage #(.SHIFT(1 << k)) u_stage (
                .din  (src.data),
                .en   (src.amt[k]),
                .op   (src.op),
                .dout (shifted)
            );

            assign st_d[k] = '{valid: src.valid, data: shifted, amt: src.amt, op: src.op};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            st_q <= '0;
        else if (!stall)
            st_q <= st_d;
    end

    assign out_valid = st_q[STAGES-1].valid;
    assign out_data  = st_q[STAGES-1].data;

`ifdef BSP_ZERO_FLAG_EN
    logic zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            zero_q <= 1'b0;
        else if (!stall)
            zero_q <= (st_d[STAGES-1].data == '0);
    end

    assign out_zero = zero_q;
`endif

    // Amount bits already consumed and the final op are carried but never read.
    logic unused_tail;
    assign unused_tail = ^{st_q[0].amt[0], st_q[1].amt[1:0], st_q[2].amt, st_q[2].op};
endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Self-checking bench for barrel_shift_pipe: directed table, corner sequences, random sweep.
module tb_barrel_shift_pipe;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic [2:0] in_amt = 3'd0;
    logic [1:0] in_op = 2'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
`ifdef BSP_ZERO_FLAG_EN
    logic       out_zero;
`endif

    int checks = 0;
    int errors = 0;

    barrel_shift_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef BSP_ZERO_FLAG_EN
        ,
        .out_zero  (out_zero)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string      nm;
        logic [7:0] d;
        logic [2:0] a;
        logic [1:0] op;
        logic [7:0] exp;
    } vec_t;

    // Reference: plain integer arithmetic on the whole word, one shift by the full amount.
    function automatic logic [7:0] ref_shift(input logic [7:0] d, input int a, input logic [1:0] op);
        int v;
        int sv;
        int r;
        v  = int'(d);
        sv = d[7] ? v - 256 : v;
        case (op)
            2'd0:    r = (v << a) & 255;
            2'd1:    r = v >> a;
            2'd2:    r = (sv >>> a) & 255;
            default: r = ((v >> a) | (v << (8 - a))) & 255;
        endcase
        return r[7:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic [2:0] a, input logic [1:0] o);
        in_valid = v;
        in_data  = d;
        in_amt   = a;
        in_op    = o;
    endtask

    // Single operand into an empty pipe; result must appear exactly 3 edges after capture.
    task automatic run_one(input vec_t t);
        out_ready = 1'b1;
        drive(1'b1, t.d, t.a, t.op);
        step();
        in_valid = 1'b0;
        step();
        chk({t.nm, "_early"}, 32'(out_valid), 32'd0);
        step();
        chk({t.nm, "_valid"}, 32'(out_valid), 32'd1);
        chk({t.nm, "_data"}, 32'(out_data), 32'(t.exp));
`ifdef BSP_ZERO_FLAG_EN
        chk({t.nm, "_zero"}, 32'(out_zero), 32'(t.exp == 8'h00));
`endif
        step();
    endtask

    vec_t       tbl[11];
    logic [7:0] sexp[4];
    logic [7:0] expq[$];

    initial begin
        tbl[0]  = '{"lsl_0f_4",  8'h0F, 3'd4, 2'd0, 8'hF0};
        tbl[1]  = '{"lsr_f0_7",  8'hF0, 3'd7, 2'd1, 8'h01};
        tbl[2]  = '{"asr_96_3",  8'h96, 3'd3, 2'd2, 8'hF2};
        tbl[3]  = '{"asr_16_3",  8'h16, 3'd3, 2'd2, 8'h02};
        tbl[4]  = '{"ror_81_1",  8'h81, 3'd1, 2'd3, 8'hC0};
        tbl[5]  = '{"ror_a5_0",  8'hA5, 3'd0, 2'd3, 8'hA5};
        tbl[6]  = '{"lsl_80_1",  8'h80, 3'd1, 2'd0, 8'h00};
        tbl[7]  = '{"lsr_80_7",  8'h80, 3'd7, 2'd1, 8'h01};
        tbl[8]  = '{"asr_80_7",  8'h80, 3'd7, 2'd2, 8'hFF};
        tbl[9]  = '{"lsl_a5_0",  8'hA5, 3'd0, 2'd0, 8'hA5};
        tbl[10] = '{"ror_12_6",  8'h12, 3'd6, 2'd3, 8'h48};

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef BSP_ZERO_FLAG_EN
        chk("rst_out_zero", 32'(out_zero), 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Empty pipe never stalls input even with out_ready low
        out_ready = 1'b0;
        #1 chk("empty_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        for (int i = 0; i < 11; i++) run_one(tbl[i]);

        // Back-to-back: results on consecutive cycles
        out_ready = 1'b1;
        drive(1'b1, 8'h0F, 3'd4, 2'd0);
        step();
        drive(1'b1, 8'hF0, 3'd7, 2'd1);
        step();
        in_valid = 1'b0;
        chk("b2b_early", 32'(out_valid), 32'd0);
        step();
        chk("b2b_first", 32'(out_data), 32'hF0);
        chk("b2b_first_v", 32'(out_valid), 32'd1);
        step();
        chk("b2b_second", 32'(out_data), 32'h01);
        chk("b2b_second_v", 32'(out_valid), 32'd1);
        step();
        chk("b2b_drained", 32'(out_valid), 32'd0);

        // Stream four operands, stall two cycles once the first result appears
        sexp[0] = 8'hF0; sexp[1] = 8'h0F; sexp[2] = 8'hE1; sexp[3] = 8'h21;
        out_ready = 1'b1;
        drive(1'b1, 8'h3C, 3'd2, 2'd0);
        step();
        drive(1'b1, 8'h3C, 3'd2, 2'd1);
        step();
        drive(1'b1, 8'hC3, 3'd1, 2'd2);
        step();
        chk("stall_first_v", 32'(out_valid), 32'd1);
        chk("stall_first_d", 32'(out_data), 32'hF0);
        out_ready = 1'b0;
        drive(1'b1, 8'h12, 3'd4, 2'd3);
        #1 chk("stall_in_ready0", 32'(in_ready), 32'd0);
        step();
        chk("stall_hold1_d", 32'(out_data), 32'hF0);
        chk("stall_hold1_v", 32'(out_valid), 32'd1);
        chk("stall_in_ready1", 32'(in_ready), 32'd0);
        step();
        chk("stall_hold2_d", 32'(out_data), 32'hF0);
        out_ready = 1'b1;
        begin
            int  k;
            logic acc;
            k = 0;
            for (int i = 0; i < 20; i++) begin
                #1;
                if (out_valid && out_ready) begin
                    if (k < 4) chk("stall_order", 32'(out_data), 32'(sexp[k]));
                    else       chk("stall_extra", 32'd1, 32'd0);
                    k++;
                end
                acc = in_valid && in_ready;
                @(negedge clk);
                if (acc) in_valid = 1'b0;
            end
            chk("stall_count", 32'(k), 32'd4);
        end

        // Async reset with three operands in flight
        out_ready = 1'b1;
        drive(1'b1, 8'h11, 3'd1, 2'd0);
        step();
        drive(1'b1, 8'h22, 3'd2, 2'd1);
        step();
        drive(1'b1, 8'h33, 3'd3, 2'd3);
        step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
`ifdef BSP_ZERO_FLAG_EN
        chk("arst_out_zero", 32'(out_zero), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        run_one('{"post_rst", 8'h96, 3'd5, 2'd2, 8'hFC});

        // Exhaustive random-throttled sweep against the reference model
        begin
            int   idx;
            int   cyc;
            logic acc;
            logic [7:0] e;
            idx = 0;
            cyc = 0;
            while ((idx < 8192 || expq.size() > 0 || in_valid) && cyc < 60000) begin
                if (!in_valid && idx < 8192 && $urandom_range(3) != 0)
                    drive(1'b1, idx[7:0], idx[10:8], idx[12:11]);
                out_ready = ($urandom_range(3) != 0);
                #1;
                if (out_valid && out_ready) begin
                    if (expq.size() > 0) begin
                        e = expq.pop_front();
                        chk("sweep_data", 32'(out_data), 32'(e));
`ifdef BSP_ZERO_FLAG_EN
                        chk("sweep_zero", 32'(out_zero), 32'(e == 8'h00));
`endif
                    end else begin
                        chk("sweep_extra", 32'd1, 32'd0);
                    end
                end
                acc = in_valid && in_ready;
                if (acc) begin
                    expq.push_back(ref_shift(in_data, int'(in_amt), in_op));
                    idx++;
                end
                @(negedge clk);
                cyc++;
                if (acc) in_valid = 1'b0;
            end
            chk("sweep_count", 32'(idx), 32'd8192);
            chk("sweep_drained", 32'(expq.size()), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
